// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner slice.
//   key_state_e        : per-key debounce FSM state (2-bit encoding)
//   DB_CYCLES_DEFAULT  : default number of stable samples required to accept a level change
package key_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'b00,
    StPressWait   = 2'b01,
    StPressed     = 2'b10,
    StReleaseWait = 2'b11
  } key_state_e;

  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/key_conditioner_if.sv
// Signal bundle between the pushbutton side and the key conditioner.
//   key_raw     : raw pushbuttons, 1 = pressed (bit0 speed key, bit1 clear key)
//   key_level   : debounced level per key
//   press_pulse : one-cycle strobe per key on each accepted press
//   quick       : speed-mode level
//   clr         : one-cycle clear strobe
// Modports: master drives key_raw and observes the rest; slave is the conditioner.
interface key_conditioner_if;
  logic [1:0] key_raw;
  logic [1:0] key_level;
  logic [1:0] press_pulse;
  logic       quick;
  logic       clr;

  modport master (
    output key_raw,
    input  key_level,
    input  press_pulse,
    input  quick,
    input  clr
  );

  modport slave (
    input  key_raw,
    output key_level,
    output press_pulse,
    output quick,
    output clr
  );
endinterface

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer followed by a 4-state debounce FSM
// with a stability counter.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   key_raw     : unsynchronized key input, 1 = pressed
//   key_level   : debounced level (1 in PRESSED and RELEASE_WAIT)
//   press_pulse : registered one-cycle strobe on entry to PRESSED from PRESS_WAIT
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse
);

  // Counter only has to reach DB_CYCLES-1.
  localparam int unsigned CntW = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sync2;
  key_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  assign sync2 = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  // State register (with counter and pulse register).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. A level reversal during a wait state always wins over
  // the terminal count, so a glitch can never be accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sync2) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!sync2) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!sync2) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (sync2) begin
          state_d = StPressed;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    pulse_d     = (state_q == StPressWait) && sync2 && (cnt_q == CntMax);
    key_level   = (state_q == StPressed) || (state_q == StReleaseWait);
    press_pulse = pulse_q;
  end

endmodule

// File: rtl/key_conditioner.sv
// Two-key conditioner: one debouncer per key, plus the speed-mode toggle and
// the registered clear strobe for the downstream counter/display block.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : key_conditioner_if.slave (key_raw in; key_level, press_pulse, quick, clr out)
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.slave   bus
);

  logic [1:0] level;
  logic [1:0] pulse;
  logic       quick_q;
  logic       clr_q;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (bus.key_raw[i]),
      .key_level   (level[i]),
      .press_pulse (pulse[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quick_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      quick_q <= quick_q ^ pulse[0];
      clr_q   <= pulse[1];
    end
  end

  assign bus.key_level   = level;
  assign bus.press_pulse = pulse;
  assign bus.quick       = quick_q;
  assign bus.clr         = clr_q;

endmodule
